// File: rtl/score_uart_tx_if.sv
// Score/game-state inputs and UART status outputs shared between the score
// display side (master) and the score transmitter (slave).
interface score_uart_tx_if;
    logic [1:0] gs;
    logic [3:0] digit3;
    logic [3:0] digit2;
    logic [3:0] digit1;
    logic [3:0] digit0;
    logic       send;
    logic       tx;
    logic       busy;
    logic       done;

    modport master (
        output gs, digit3, digit2, digit1, digit0, send,
        input  tx, busy, done
    );

    modport slave (
        input  gs, digit3, digit2, digit1, digit0, send,
        output tx, busy, done
    );
endinterface

// File: rtl/score_uart_tx.sv
// Snapshots the 4-digit BCD score on game over (or manual send) and transmits
// it as ASCII over UART 8N1, followed by CR LF.
module score_uart_tx #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int BAUD         = 115_200,
    parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
    input  logic           clk,
    input  logic           reset_n,
    score_uart_tx_if.slave bus,
    output logic [1:0]     state_dbg
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0] LAST_BYTE = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       gs_q;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [2:0]       byte_idx_q, byte_idx_d;
    logic [15:0]      snap_q, snap_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             trigger;
    logic             cnt_last;
    logic [7:0]       cur_byte;

    // Handshake: send is a one-cycle request honoured only while busy is low;
    // requests and game-over edges seen while busy are dropped, never queued.
    assign trigger  = (state_q == S_IDLE) &&
                      (((bus.gs == 2'd2) && (gs_q != 2'd2)) || bus.send);
    assign cnt_last = (bit_cnt_q == CNT_LAST);

    function automatic logic [7:0] to_ascii(input logic [3:0] d);
        return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h3F;
    endfunction

    function automatic logic [7:0] msg_byte(input logic [15:0] snap, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = to_ascii(snap[15:12]);
            3'd1:    b = to_ascii(snap[11:8]);
            3'd2:    b = to_ascii(snap[7:4]);
            3'd3:    b = to_ascii(snap[3:0]);
            3'd4:    b = 8'h0D;
            default: b = 8'h0A;
        endcase
        return b;
    endfunction

    // State register; outputs are registered from their next values so tx is glitch-free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            gs_q       <= 2'd0;
            bit_cnt_q  <= '0;
            bit_idx_q  <= 3'd0;
            byte_idx_q <= 3'd0;
            snap_q     <= 16'h0000;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gs_q       <= bus.gs;
            bit_cnt_q  <= bit_cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            snap_q     <= snap_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state, counters and snapshot.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = '0;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        snap_d     = snap_q;
        if (state_q != S_IDLE) begin
            bit_cnt_d = cnt_last ? '0 : bit_cnt_q + 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    state_d    = S_START;
                    bit_idx_d  = 3'd0;
                    byte_idx_d = 3'd0;
                    snap_d     = {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
                end
            end
            S_START: begin
                if (cnt_last) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_last) begin
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                // Next start bit follows the stop bit with no idle gap.
                if (cnt_last) begin
                    if (byte_idx_q < LAST_BYTE) begin
                        state_d    = S_START;
                        byte_idx_d = byte_idx_q + 3'd1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output values for the coming cycle.
    always_comb begin
        cur_byte = msg_byte(snap_d, byte_idx_d);
        tx_d     = 1'b1;
        case (state_d)
            S_IDLE:  tx_d = 1'b1;
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = cur_byte[bit_idx_d];
            S_STOP:  tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_q == S_STOP) && cnt_last && (byte_idx_q == LAST_BYTE);
    end

    assign bus.tx    = tx_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_score_uart_tx.sv
// Directed bench for score_uart_tx at 16 clocks per bit (960-cycle messages).
module tb_score_uart_tx;
    localparam int CPB = 16;
    localparam int MSG = 60 * CPB;
    localparam int CAP = 1200;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] state_dbg;
    int         checks = 0;
    int         errors = 0;

    logic cap_tx   [0:CAP-1];
    logic cap_busy [0:CAP-1];
    logic cap_done [0:CAP-1];

    score_uart_tx_if bus ();

    score_uart_tx #(.CLK_HZ(16), .BAUD(1)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #(2_000_000);
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    // Records outputs once per cycle, starting in the current negedge slot.
    task automatic capture(input int n);
        for (int c = 0; c < n; c++) begin
            cap_tx[c]   = bus.tx;
            cap_busy[c] = bus.busy;
            cap_done[c] = bus.done;
            @(negedge clk);
        end
    endtask

    task automatic set_digits(input logic [15:0] d);
        bus.digit3 = d[15:12];
        bus.digit2 = d[11:8];
        bus.digit1 = d[7:4];
        bus.digit0 = d[3:0];
    endtask

    // Returns on the negedge right after the trigger edge (capture cycle 0).
    task automatic pulse_send(input logic [15:0] d);
        @(negedge clk);
        set_digits(d);
        bus.send = 1'b1;
        @(negedge clk);
        bus.send = 1'b0;
    endtask

    function automatic logic [7:0] rx_byte(input int j);
        logic [7:0] v;
        for (int b = 0; b < 8; b++) v[b] = cap_tx[j*160 + CPB*(b+1) + 8];
        return v;
    endfunction

    function automatic logic exp_tx(input logic [47:0] m, input int c);
        int j;
        int k;
        logic [7:0] byt;
        j = c / 160;
        k = (c % 160) / CPB;
        if (j >= 6) return 1'b1;
        byt = m[47 - 8*j -: 8];
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return byt[k-1];
    endfunction

    function automatic int wave_errs(input logic [47:0] m, input int n);
        int e = 0;
        for (int c = 0; c < n; c++) if (cap_tx[c] !== exp_tx(m, c)) e++;
        return e;
    endfunction

    function automatic int count_busy(input int n);
        int s = 0;
        for (int c = 0; c < n; c++) if (cap_busy[c] === 1'b1) s++;
        return s;
    endfunction

    function automatic int count_done(input int n);
        int s = 0;
        for (int c = 0; c < n; c++) if (cap_done[c] === 1'b1) s++;
        return s;
    endfunction

    task automatic test_reset;
        reset_n = 1'b0;
        bus.gs = 2'd0;
        bus.send = 1'b0;
        set_digits(16'h0000);
        #12;
        checks++;
        if ({bus.tx, bus.busy, bus.done} !== 3'b100) begin
            errors++;
            $display("FAIL reset_outputs: tx/busy/done got %b expected 100", {bus.tx, bus.busy, bus.done});
        end
        checks++;
        if (state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d expected 0", state_dbg);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_gs_edge;
        logic [47:0] m = 48'h30_34_32_37_0D_0A;
        bus.gs = 2'd1;
        set_digits(16'h0427);
        repeat (3) @(negedge clk);
        bus.gs = 2'd2;
        @(negedge clk);
        capture(1000);
        for (int j = 0; j < 6; j++) begin
            checks++;
            if (rx_byte(j) !== m[47 - 8*j -: 8]) begin
                errors++;
                $display("FAIL gs_edge_byte%0d: got %02h expected %02h", j, rx_byte(j), m[47 - 8*j -: 8]);
            end
        end
        checks++;
        if (count_busy(1000) !== MSG) begin
            errors++;
            $display("FAIL gs_edge_busy_cycles: got %0d expected %0d", count_busy(1000), MSG);
        end
        checks++;
        if (count_done(1000) !== 1) begin
            errors++;
            $display("FAIL gs_edge_done_count: got %0d expected 1", count_done(1000));
        end
        checks++;
        if ({cap_busy[MSG-1], cap_busy[MSG], cap_done[MSG]} !== 3'b101) begin
            errors++;
            $display("FAIL gs_edge_end_timing: busy959/busy960/done960 got %b expected 101",
                     {cap_busy[MSG-1], cap_busy[MSG], cap_done[MSG]});
        end
        checks++;
        if (wave_errs(m, 1000) !== 0) begin
            errors++;
            $display("FAIL gs_edge_waveform: got %0d bad cycles expected 0", wave_errs(m, 1000));
        end
    endtask

    task automatic test_send_hold;
        logic [47:0] m = 48'h39_39_39_39_0D_0A;
        bus.gs = 2'd1;
        repeat (3) @(negedge clk);
        pulse_send(16'h9999);
        fork
            capture(CAP);
            begin
                repeat (5) @(negedge clk);
                bus.gs = 2'd2;
            end
        join
        for (int j = 0; j < 6; j++) begin
            checks++;
            if (rx_byte(j) !== m[47 - 8*j -: 8]) begin
                errors++;
                $display("FAIL send_byte%0d: got %02h expected %02h", j, rx_byte(j), m[47 - 8*j -: 8]);
            end
        end
        checks++;
        if (count_busy(CAP) !== MSG) begin
            errors++;
            $display("FAIL send_no_retrigger: busy cycles got %0d expected %0d", count_busy(CAP), MSG);
        end
        checks++;
        if (count_done(CAP) !== 1) begin
            errors++;
            $display("FAIL send_done_count: got %0d expected 1", count_done(CAP));
        end
    endtask

    task automatic test_snapshot;
        logic [47:0] m = 48'h31_32_3F_34_0D_0A;
        bus.gs = 2'd1;
        repeat (3) @(negedge clk);
        pulse_send(16'h12B4);
        fork
            capture(1000);
            begin
                repeat (10) @(negedge clk);
                set_digits(16'h5678);
            end
        join
        checks++;
        if (rx_byte(2) !== 8'h3F) begin
            errors++;
            $display("FAIL snapshot_invalid_digit: got %02h expected 3f", rx_byte(2));
        end
        checks++;
        if (wave_errs(m, 1000) !== 0) begin
            errors++;
            $display("FAIL snapshot_waveform: got %0d bad cycles expected 0", wave_errs(m, 1000));
        end
    endtask

    task automatic test_busy_ignore;
        logic [47:0] m = 48'h33_31_34_31_0D_0A;
        bus.gs = 2'd1;
        repeat (3) @(negedge clk);
        pulse_send(16'h3141);
        fork
            capture(CAP);
            begin
                repeat (100) @(negedge clk);
                bus.send = 1'b1;
                @(negedge clk);
                bus.send = 1'b0;
                repeat (199) @(negedge clk);
                bus.gs = 2'd2;
                repeat (200) @(negedge clk);
                bus.send = 1'b1;
                @(negedge clk);
                bus.send = 1'b0;
                repeat (458) @(negedge clk);
                bus.send = 1'b1;
                @(negedge clk);
                bus.send = 1'b0;
            end
        join
        checks++;
        if (count_busy(CAP) !== MSG) begin
            errors++;
            $display("FAIL busy_ignore_cycles: got %0d expected %0d", count_busy(CAP), MSG);
        end
        checks++;
        if (count_done(CAP) !== 1) begin
            errors++;
            $display("FAIL busy_ignore_done: got %0d expected 1", count_done(CAP));
        end
        checks++;
        if (wave_errs(m, CAP) !== 0) begin
            errors++;
            $display("FAIL busy_ignore_waveform: got %0d bad cycles expected 0", wave_errs(m, CAP));
        end
    endtask

    task automatic test_reset_mid;
        logic [47:0] m = 48'h32_30_32_35_0D_0A;
        int dn = 0;
        bus.gs = 2'd1;
        repeat (3) @(negedge clk);
        pulse_send(16'h5555);
        capture(200);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.tx, bus.busy} !== 2'b10) begin
            errors++;
            $display("FAIL reset_mid_async: tx/busy got %b expected 10", {bus.tx, bus.busy});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dn++;
        end
        reset_n = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dn++;
        end
        checks++;
        if (dn !== 0 || state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid_no_done: done pulses %0d state %0d expected 0 and 0", dn, state_dbg);
        end
        pulse_send(16'h2025);
        capture(1000);
        checks++;
        if (wave_errs(m, 1000) !== 0) begin
            errors++;
            $display("FAIL reset_mid_resend: got %0d bad cycles expected 0", wave_errs(m, 1000));
        end
        checks++;
        if (count_done(1000) !== 1) begin
            errors++;
            $display("FAIL reset_mid_resend_done: got %0d expected 1", count_done(1000));
        end
    endtask

    task automatic test_bit_timing;
        int low;
        bus.gs = 2'd1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.tx !== 1'b1) begin
            errors++;
            $display("FAIL timing_idle_tx: got %b expected 1", bus.tx);
        end
        pulse_send(16'h0000);
        capture(1000);
        for (int j = 0; j < 6; j++) begin
            low = 0;
            for (int c = j*160; c < j*160 + CPB; c++) if (cap_tx[c] === 1'b0) low++;
            if (j > 0 && cap_tx[j*160 - 1] !== 1'b1) low = -1;
            if (cap_tx[j*160 + CPB + 8 + 8*CPB] !== 1'b1) low = -2;
            checks++;
            if (low !== CPB) begin
                errors++;
                $display("FAIL timing_start_bit%0d: low cycles got %0d expected %0d", j, low, CPB);
            end
        end
        checks++;
        if (rx_byte(0) !== 8'h30) begin
            errors++;
            $display("FAIL timing_lsb_first: got %02h expected 30", rx_byte(0));
        end
        checks++;
        if ({cap_tx[24], cap_tx[72], cap_tx[88], cap_tx[104], cap_tx[120]} !== 5'b00110) begin
            errors++;
            $display("FAIL timing_bit_order: bits0/3/4/5/6 got %b expected 00110",
                     {cap_tx[24], cap_tx[72], cap_tx[88], cap_tx[104], cap_tx[120]});
        end
    endtask

    initial begin
        test_reset();
        test_gs_edge();
        test_send_hold();
        test_snapshot();
        test_busy_ignore();
        test_reset_mid();
        test_bit_timing();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
